// File: rtl/led_shift_driver.sv
// led_shift_driver: parallel-to-serial driver for a 74HC595-style LED chain with divided sclk and latch strobe.
module led_shift_driver #(
  parameter int DATA_BITS = 16,
  parameter int CNT_BITS  = 4,
  parameter int DIR       = 0,
  parameter int CLK_DIV   = 2,
  parameter int DIV_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] pdata,
  output logic                 sclk,
  output logic                 sout,
  output logic                 sclrn,
  output logic                 en,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DATA_BITS - 1);
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DIV_BITS-1:0]  div_q, div_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 sclk_q, sclk_d, en_q, en_d, busy_q, busy_d, done_q, done_d, sclrn_q;
  logic                 wrap;
  logic [DATA_BITS-1:0] shifted;
  assign wrap    = div_q == DIV_LAST;
  assign shifted = (DIR == 0) ? {shreg_q[DATA_BITS-2:0], 1'b0} : {1'b0, shreg_q[DATA_BITS-1:1]};
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        shreg_d = pdata;
        busy_d  = 1'b1;
        sclk_d  = 1'b0;
        div_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap && !sclk_q) sclk_d = 1'b1;
        // falling toggle: advance to the next bit, or finish after the last high phase
        if (wrap && sclk_q) begin
          sclk_d  = 1'b0;
          shreg_d = shifted;
          cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          en_d    = cnt_q == CNT_LAST;
          state_d = (cnt_q == CNT_LAST) ? LATCH : SHIFT;
        end
      end
      LATCH: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclrn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclrn_q <= 1'b1;
    end
  end
  assign sout  = (DIR == 0) ? shreg_q[DATA_BITS-1] : shreg_q[0];
  assign sclk  = sclk_q;
  assign sclrn = sclrn_q;
  assign en    = en_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_led_shift_driver.sv
// tb_led_shift_driver: directed checks of three driver configurations (MSB/D=2, LSB/D=2, MSB/D=1).
module tb_led_shift_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pdata = '0;
  logic [2:0]  sclk, sout, sclrn, en, busy, done;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  led_shift_driver #(.DIR(0), .CLK_DIV(2)) u0 (.clk(clk), .rst(rst), .start(start), .pdata(pdata),
    .sclk(sclk[0]), .sout(sout[0]), .sclrn(sclrn[0]), .en(en[0]), .busy(busy[0]), .done(done[0]));
  led_shift_driver #(.DIR(1), .CLK_DIV(2)) u1 (.clk(clk), .rst(rst), .start(start), .pdata(pdata),
    .sclk(sclk[1]), .sout(sout[1]), .sclrn(sclrn[1]), .en(en[1]), .busy(busy[1]), .done(done[1]));
  led_shift_driver #(.DIR(0), .CLK_DIV(1)) u2 (.clk(clk), .rst(rst), .start(start), .pdata(pdata),
    .sclk(sclk[2]), .sout(sout[2]), .sclrn(sclrn[2]), .en(en[2]), .busy(busy[2]), .done(done[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle;
    int n = 0;
    while ((busy !== 3'b000) && n < 200) begin
      tick;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'h0);
  endtask
  // one transfer started at t0; c counts edges after t0
  task automatic xfer(input logic [15:0] w, input logic [15:0] w_rev, input bit repulse);
    logic [15:0] g0, g1, g2;
    g0 = '0; g1 = '0; g2 = '0;
    pdata = w;
    start = 1'b1;
    tick;
    start = 1'b0;
    pdata = ~w;
    for (int c = 1; c <= 70; c++) begin
      start = repulse && c == 10;
      tick;
      if (c % 4 == 2 && c <= 62) begin
        g0 = {g0[14:0], sout[0]};
        g1 = {g1[14:0], sout[1]};
      end
      if (c % 2 == 1 && c <= 31) g2 = {g2[14:0], sout[2]};
      if (c == 1 || c == 2 || c == 4) chk("sclk0_phase", 32'(sclk[0]), 32'(c == 2));
      if (c == 1 || c == 2) chk("sclk2_phase", 32'(sclk[2]), 32'(c == 1));
      if (c >= 63 && c <= 66) chk("en0", 32'(en[0]), 32'(c == 64 || c == 65));
      if (c == 65 || c == 66) begin
        chk("done0", 32'(done[0]), 32'(c == 66));
        chk("busy0", 32'(busy[0]), 32'(c == 65));
      end
      if (c == 32 || c == 33) begin
        chk("en2", 32'(en[2]), 32'(c == 32));
        chk("done2", 32'(done[2]), 32'(c == 33));
      end
      if (c == 67) chk("done0_clear", 32'(done[0]), 32'h0);
      if (c == 70) chk("busy0_no_requeue", 32'(busy[0]), 32'h0);
    end
    chk("bits_msb_d2", 32'(g0), 32'(w));
    chk("bits_lsb_d2", 32'(g1), 32'(w_rev));
    chk("bits_msb_d1", 32'(g2), 32'(w));
    chk("sout0_after", 32'(sout[0]), 32'h0);
    wait_idle;
  endtask
  initial begin
    logic [15:0] h0, h1, hr;
    logic        any;
    for (int i = 0; i < 3; i++) tick;
    chk("rst_sclrn", 32'(sclrn), 32'h0);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_sout", 32'(sout), 32'h0);
    rst = 1'b1;
    tick;
    chk("sclrn_up", 32'(sclrn), 32'h7);
    tick;
    xfer(16'hA55A, 16'h5AA5, 1'b0);
    xfer(16'hA55A, 16'h5AA5, 1'b1);
    xfer(16'hC381, 16'h81C3, 1'b0);
    // start held high: back-to-back transfers 67 cycles apart on u0
    h0 = '0; h1 = '0; hr = '0;
    pdata = 16'h0001;
    start = 1'b1;
    tick;
    for (int c = 1; c <= 140; c++) begin
      int r;
      tick;
      r = (c >= 67) ? c - 67 : c;
      if (r % 4 == 2 && r <= 62 && c < 67) begin
        h0 = {h0[14:0], sout[0]};
        hr = {hr[14:0], sout[1]};
      end
      if (r % 4 == 2 && r <= 62 && c >= 67 && c < 134) h1 = {h1[14:0], sout[0]};
      if (c == 66 || c == 133) chk("held_done0", 32'(done[0]), 32'h1);
      if (c == 67) chk("held_busy0", 32'(busy[0]), 32'h1);
    end
    start = 1'b0;
    chk("held_bits_a", 32'(h0), 32'h0001);
    chk("held_bits_b", 32'(h1), 32'h0001);
    chk("held_bits_lsb", 32'(hr), 32'h8000);
    wait_idle;
    // reset mid-transfer
    any = 1'b0;
    pdata = 16'hA55A;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      rst = !(c == 20 || c == 21);
      tick;
      if (c == 20) begin
        chk("abort_sclk", 32'(sclk), 32'h0);
        chk("abort_en", 32'(en), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_sclrn", 32'(sclrn), 32'h0);
      end
      if (c == 21) chk("abort_sclrn_hold", 32'(sclrn), 32'h0);
      if (c == 22) chk("abort_sclrn_up", 32'(sclrn), 32'h7);
      if (c >= 20) any = any | (|en) | (|done) | (|busy);
    end
    chk("abort_no_pulse", 32'(any), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_shift_driver.md
# led_shift_driver

Parallel-to-serial driver for the board's daisy-chained LED shift register (74HC595-style). It sits directly downstream of the GPIO register block, which supplies the parallel LED word and a start request. On each accepted start it shifts the word out on a divided serial clock with selectable bit order, then pulses the output-latch enable. It reports busy and done status to the GPIO block.

## Interface
- `DATA_BITS`, default 16: width of the parallel word and number of serial bits per transfer.
- `CNT_BITS`, default 4: bit-counter width; 2^CNT_BITS >= DATA_BITS is required.
- `DIR`, default 0: bit order; 0 = MSB first, 1 = LSB first.
- `CLK_DIV`, default 2: `clk` cycles per `sclk` half-period; must be >= 1.
- `DIV_BITS`, default 8: divider-counter width; 2^DIV_BITS > CLK_DIV is required.

Ports:
- `clk` input 1: single system clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `start` input 1: transfer request, level-sampled; accepted only in IDLE.
- `pdata` input DATA_BITS: parallel word, captured on the accepting edge only.
- `sclk` output 1: serial shift clock to the LED chain; the shift register samples `sout` on the rising edge of `sclk`.
- `sout` output 1: serial data.
- `sclrn` output 1: active-low clear to the LED chain.
- `en` output 1: output-latch strobe, high for CLK_DIV cycles after the last bit.
- `busy` output 1: high from acceptance until `done`.
- `done` output 1: one-cycle completion pulse.

## Operation
- States are IDLE, SHIFT and LATCH.
- Reset (`rst`=0 at an edge) forces the following, and applies from any state including mid-transfer:
  - state IDLE;
  - `sclk`=0, `en`=0, `busy`=0, `done`=0, `sclrn`=0;
  - shift register and all counters cleared.
- `sclrn` is registered. It goes to 1 on the first edge with `rst`=1 and stays 1 until the next reset.
- IDLE with `start`=1 (leaving IDLE):
  - capture `pdata` into the shift register;
  - set `busy`=1, `sclk`=0, divider=0, bit count=0;
  - go to SHIFT.
- SHIFT:
  - The divider counts 0..CLK_DIV-1. On each wrap, `sclk` toggles.
  - On a wrap with `sclk`=1 (the falling toggle), the shift register shifts by one position toward the output bit.
  - At the same falling toggle, the bit count increments. When the last bit's high phase ends (bit count = DATA_BITS-1), the block sets `sclk`=0 and `en`=1 and goes to LATCH instead.
- `sout` is combinational from the shift register: bit DATA_BITS-1 when DIR=0, bit 0 when DIR=1. It is stable for the whole of each `sclk` period.
- Shift fill value is 0. After a transfer, `sout` reads 0.
- LATCH:
  - The divider counts CLK_DIV cycles.
  - It then sets `en`=0, `busy`=0 and `done`=1, and goes to IDLE.
- `done` clears on the next edge.
- `start` while `busy`=1 is ignored; there is no queuing.
- `start` held high re-triggers: the next transfer is accepted on the cycle in which `done`=1.
- `pdata` changes during a transfer have no effect on it.

## Timing
Let t0 be the accepting edge, N = DATA_BITS and D = CLK_DIV.
- Bit k (k = 0..N-1) is on `sout` from edge t0+2kD to t0+2(k+1)D.
- `sclk` rises at t0+(2k+1)D and falls at t0+2(k+1)D.
- `en`=1 from edge t0+2ND to edge t0+2ND+D.
- `done`=1 and `busy`=0 from edge t0+2ND+D, for one cycle.
- Total latency from acceptance to `done` is 2ND+D cycles. Defaults: 66 cycles.
- Minimum repeat period with `start` held high is 2ND+D+1 cycles.
- A reset mid-transfer aborts it with no `en` or `done` pulse.

## Test plan
- Reset, then `pdata`=16'hA55A, one-cycle `start`, DIR=0, D=2:
  - `sout` sampled at the 16 `sclk` rising edges (t0+2, +6, …, +62) reads 1010010101011010;
  - `en` high t0+64..+65;
  - `done` at t0+66.
- Same word with DIR=1: sampled bits are 0101101010100101.
- `start` pulsed again at t0+10 during the transfer: no effect; bit stream and `done` timing unchanged.
- `start` held high continuously with `pdata`=16'h0001: transfers begin at t0 and t0+67; each shows a single 1 on the 16th sampled bit.
- `rst`=0 at t0+20: on the next edge, `sclk`, `en`, `busy` and `done` are 0 and `sclrn`=0. No `en` pulse follows. `sclrn` returns to 1 one cycle after `rst` is released.
- D=1, N=16: rising `sclk` edges every 2 cycles starting at t0+1; `done` at t0+33.
